timer_multi_ch: RTL

Parametrised multi-channel down-counting timer. It generalises the single-channel load/enable down counter to NUM_CH independent channels. New capabilities: a shared programmable prescaler, per-channel one-shot or auto-reload mode, start/stop control, a one-cycle expiry pulse and a sticky interrupt flag. It sits beside the single timer in the timer unit and serves as the system's general-purpose event/timeout source.

---
 rtl/timer_pkg.sv | 29 ++
 rtl/timer_multi_ch_if.sv | 36 +++
 rtl/timer_ch.sv | 111 +++++++++++
 rtl/timer_multi_ch.sv | 73 +++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the multi-channel down-counting timer.
package timer_pkg;

    // Default geometry; the top and the interface take these as parameter defaults.
    localparam int DEF_WIDTH     = 4;
    localparam int DEF_NUM_CH    = 4;
    localparam int DEF_PRE_WIDTH = 4;

    // Per-channel control state.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

    // Per-channel command strobes, bundled so each channel gets one port.
    typedef struct packed {
        logic load;
        logic start;
        logic stop;
        logic auto_reload;
        logic irq_clr;
    } ch_cmd_t;

    // Lowest bit of channel ch inside a flat NUM_CH*width vector.
    function automatic int ch_lsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/timer_multi_ch_if.sv
// Control/status bundle between a bus master and the multi-channel timer.
interface timer_multi_ch_if
    import timer_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int PRE_WIDTH = DEF_PRE_WIDTH
);

    // Controls from the master.
    logic [PRE_WIDTH-1:0]      prescale;
    logic [NUM_CH-1:0]         load_en;
    logic [NUM_CH*WIDTH-1:0]   load_data;
    logic [NUM_CH-1:0]         start;
    logic [NUM_CH-1:0]         stop;
    logic [NUM_CH-1:0]         auto_reload;
    logic [NUM_CH-1:0]         irq_clr;

    // Status from the timer.
    logic [NUM_CH*WIDTH-1:0]   cnt_out;
    logic [NUM_CH-1:0]         running;
    logic [NUM_CH-1:0]         cnt_one;
    logic [NUM_CH-1:0]         expire;
    logic [NUM_CH-1:0]         irq;

    modport master (
        output prescale, load_en, load_data, start, stop, auto_reload, irq_clr,
        input  cnt_out, running, cnt_one, expire, irq
    );

    modport slave (
        input  prescale, load_en, load_data, start, stop, auto_reload, irq_clr,
        output cnt_out, running, cnt_one, expire, irq
    );

endinterface

// File: rtl/timer_ch.sv
// One timer channel: IDLE/RUN control, down counter, reload register,
// registered expiry pulse and sticky interrupt flag. Advances only on tick.
module timer_ch
    import timer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             i_clk,
    input  logic             rst,
    input  logic             tick,
    input  ch_cmd_t          cmd,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] cnt,
    output logic             running,
    output logic             cnt_one,
    output logic             expire,
    output logic             irq
);

    ch_state_e        state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             expire_q, expire_d;
    logic             irq_q, irq_d;
    logic [WIDTH-1:0] eff_cnt;

    // State register: every flop of the channel, synchronous reset.
    always_ff @(posedge i_clk) begin
        // NOTE: reload is an ordinary register, not a memory, so it is reset
        // with everything else and a post-reset auto-reload sees a clean 0.
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            reload_q <= '0;
            expire_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            expire_q <= expire_d;
            irq_q    <= irq_d;
        end
    end

    // Next-state logic: command priority stop > load > start, then counting.
    always_comb begin
        // NOTE: every target gets a default first so no path infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        expire_d = 1'b0;
        irq_d    = irq_q & ~cmd.irq_clr;
        eff_cnt  = cmd.load ? load_data : cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (!cmd.stop) begin
                    if (cmd.load) begin
                        cnt_d    = load_data;
                        reload_d = load_data;
                    end
                    // A start with nothing to count down is dropped.
                    if (cmd.start && (eff_cnt != '0)) begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (cmd.stop) begin
                    // Pause: count is held and a stop on the expiry tick
                    // suppresses both the pulse and the irq set.
                    state_d = ST_IDLE;
                end else begin
                    // A load while running only arms the next period.
                    if (cmd.load) begin
                        reload_d = load_data;
                    end
                    if (tick) begin
                        if (cnt_q > WIDTH'(1)) begin
                            cnt_d = cnt_q - WIDTH'(1);
                        end else if (cnt_q == WIDTH'(1)) begin
                            expire_d = 1'b1;
                            irq_d    = 1'b1;
                            if (cmd.auto_reload && (reload_q != '0)) begin
                                cnt_d = reload_q;
                            end else begin
                                cnt_d   = '0;
                                state_d = ST_IDLE;
                            end
                        end
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: registered status plus the combinational terminal-count hint.
    always_comb begin
        cnt     = cnt_q;
        running = (state_q == ST_RUN);
        cnt_one = (state_q == ST_RUN) && (cnt_q == WIDTH'(1));
        expire  = expire_q;
        irq     = irq_q;
    end

endmodule

// File: rtl/timer_multi_ch.sv
// Multi-channel down-counting timer: one shared prescaler producing tick,
// and NUM_CH independent timer_ch channels advanced by it.
module timer_multi_ch
    import timer_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int PRE_WIDTH = DEF_PRE_WIDTH
) (
    input  logic               i_clk,
    input  logic               rst,
    timer_multi_ch_if.slave    bus
);

    logic [PRE_WIDTH-1:0]          pre_cnt_q, pre_cnt_d;
    logic                          tick;

    logic [NUM_CH-1:0][WIDTH-1:0]  cnt_arr;
    logic [NUM_CH-1:0]             running_v;
    logic [NUM_CH-1:0]             cnt_one_v;
    logic [NUM_CH-1:0]             expire_v;
    logic [NUM_CH-1:0]             irq_v;

    // Prescaler next state: tick on match, then restart from 0. If prescale
    // drops below the running count the counter wraps through all-ones.
    always_comb begin
        tick      = (pre_cnt_q == bus.prescale);
        pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_WIDTH'(1);
    end

    // Prescaler register; only rst restarts it.
    always_ff @(posedge i_clk) begin
        if (rst) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        localparam int LSB = ch_lsb(k, WIDTH);

        ch_cmd_t ch_cmd;

        assign ch_cmd.load        = bus.load_en[k];
        assign ch_cmd.start       = bus.start[k];
        assign ch_cmd.stop        = bus.stop[k];
        assign ch_cmd.auto_reload = bus.auto_reload[k];
        assign ch_cmd.irq_clr     = bus.irq_clr[k];

        timer_ch #(
            .WIDTH (WIDTH)
        ) u_ch (
            .i_clk     (i_clk),
            .rst       (rst),
            .tick      (tick),
            .cmd       (ch_cmd),
            .load_data (bus.load_data[LSB +: WIDTH]),
            .cnt       (cnt_arr[k]),
            .running   (running_v[k]),
            .cnt_one   (cnt_one_v[k]),
            .expire    (expire_v[k]),
            .irq       (irq_v[k])
        );
    end

    assign bus.cnt_out = cnt_arr;
    assign bus.running = running_v;
    assign bus.cnt_one = cnt_one_v;
    assign bus.expire  = expire_v;
    assign bus.irq     = irq_v;

endmodule
